// File: rtl/hazard_tag_pipeline_pkg.sv
// Shared constants for the hazard/forwarding tag pipeline: register address width,
// freeze FSM state encoding and the all-zero bubble tag.
package hazard_tag_pipeline_pkg;

  localparam int REGISTER_FILE_ADDRESS_LEN = 4;

  typedef enum logic {
    FREEZE_FSM_RUN  = 1'b0,
    FREEZE_FSM_WAIT = 1'b1
  } freeze_state_e;

  typedef struct packed {
    logic [REGISTER_FILE_ADDRESS_LEN-1:0] dest;
    logic                                 wb_en;
    logic                                 mem_read;
  } tag_t;

  localparam tag_t TAG_BUBBLE = '{dest: 4'd0, wb_en: 1'b0, mem_read: 1'b0};

endpackage

// File: rtl/hazard_tag_pipeline_dest_tag_stage.sv
// One register stage of the {dest, wb_en, mem_read} tag: async clear, hold for
// pipeline freeze and a bubble input that loads the all-zero tag.
module hazard_tag_pipeline_dest_tag_stage
  import hazard_tag_pipeline_pkg::*;
#(
  parameter int TAG_W = REGISTER_FILE_ADDRESS_LEN + 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             bubble,
  input  logic [TAG_W-1:0] d,
  output logic [TAG_W-1:0] q
);

  localparam logic [TAG_W-1:0] BUBBLE_TAG = TAG_W'(TAG_BUBBLE);

  logic [TAG_W-1:0] tag_r;

  // Tag register: hold wins over bubble, bubble wins over new data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_r <= BUBBLE_TAG;
    end else if (hold) begin
      tag_r <= tag_r;
    end else if (bubble) begin
      tag_r <= BUBBLE_TAG;
    end else begin
      tag_r <= d;
    end
  end

  assign q = tag_r;

endmodule

// File: rtl/hazard_tag_pipeline.sv
// Destination-tag pipeline (EXE/MEM/WB), hazard stall detection and data-memory
// freeze FSM. Optional stall/freeze cycle counters under `HAZARD_STATS_EN`.
module hazard_tag_pipeline
  import hazard_tag_pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = REGISTER_FILE_ADDRESS_LEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  forwarding_enable,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_two_src,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_wb_en,
  input  logic                  id_mem_read,
  input  logic                  flush,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  hazard_stall,
  output logic                  freeze,
  output logic [REG_ADDR_W-1:0] exe_dest,
  output logic [REG_ADDR_W-1:0] mem_dest,
  output logic [REG_ADDR_W-1:0] wb_dest,
  output logic                  exe_wb_en,
  output logic                  mem_wb_en,
  output logic                  wb_wb_en,
`ifdef HAZARD_STATS_EN
  output logic [15:0]           stall_cycles,
  output logic [15:0]           freeze_cycles,
`endif
  output logic                  exe_mem_read
);

  localparam int TAG_W = REG_ADDR_W + 2;

  logic [TAG_W-1:0] id_tag_s;
  logic [TAG_W-1:0] exe_tag_s;
  logic [TAG_W-1:0] mem_tag_s;
  logic [TAG_W-1:0] wb_tag_s;
  logic             exe_bubble_s;
  logic             raw_hazard_s;
  logic             use_exe_s;
  logic             use_mem_s;
  logic             freeze_s;
  freeze_state_e    state_r;
  freeze_state_e    state_next_s;

  assign id_tag_s     = {id_dest, id_wb_en, id_mem_read};
  assign exe_bubble_s = hazard_stall | flush | ~id_valid;

  hazard_tag_pipeline_dest_tag_stage #(.TAG_W(TAG_W)) u_exe_stage (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (freeze_s),
    .bubble (exe_bubble_s),
    .d      (id_tag_s),
    .q      (exe_tag_s)
  );

  hazard_tag_pipeline_dest_tag_stage #(.TAG_W(TAG_W)) u_mem_stage (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (freeze_s),
    .bubble (1'b0),
    .d      (exe_tag_s),
    .q      (mem_tag_s)
  );

  hazard_tag_pipeline_dest_tag_stage #(.TAG_W(TAG_W)) u_wb_stage (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (freeze_s),
    .bubble (1'b0),
    .d      (mem_tag_s),
    .q      (wb_tag_s)
  );

  assign {exe_dest, exe_wb_en, exe_mem_read} = exe_tag_s;
  assign mem_dest = mem_tag_s[TAG_W-1:2];
  assign mem_wb_en = mem_tag_s[1];
  assign wb_dest  = wb_tag_s[TAG_W-1:2];
  assign wb_wb_en = wb_tag_s[1];

  // Source match against EXE/MEM destinations; src2 only when actually read.
  always_comb begin
    use_exe_s    = 1'b0;
    use_mem_s    = 1'b0;
    raw_hazard_s = 1'b0;
    use_exe_s = (id_src1 == exe_dest) | (id_two_src & (id_src2 == exe_dest));
    use_mem_s = (id_src1 == mem_dest) | (id_two_src & (id_src2 == mem_dest));
    if (forwarding_enable) begin
      raw_hazard_s = id_valid & exe_wb_en & exe_mem_read & use_exe_s;
    end else begin
      raw_hazard_s = id_valid & ((exe_wb_en & use_exe_s) | (mem_wb_en & use_mem_s));
    end
  end

  // Freeze FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FREEZE_FSM_RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Freeze is combinational so the first wait cycle is already frozen.
  always_comb begin
    state_next_s = state_r;
    freeze_s     = 1'b0;
    case (state_r)
      FREEZE_FSM_RUN: begin
        freeze_s = rst_n & mem_req & ~mem_ready;
        if (mem_req && !mem_ready) begin
          state_next_s = FREEZE_FSM_WAIT;
        end else begin
          state_next_s = FREEZE_FSM_RUN;
        end
      end
      FREEZE_FSM_WAIT: begin
        freeze_s = rst_n & ~mem_ready;
        if (mem_ready) begin
          state_next_s = FREEZE_FSM_RUN;
        end else begin
          state_next_s = FREEZE_FSM_WAIT;
        end
      end
      default: begin
        freeze_s     = 1'b0;
        state_next_s = FREEZE_FSM_RUN;
      end
    endcase
  end

  assign freeze       = freeze_s;
  assign hazard_stall = rst_n & raw_hazard_s & ~freeze_s;

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cycles_r;
  logic [15:0] freeze_cycles_r;

  // Saturating stall/freeze cycle counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_r  <= 16'd0;
      freeze_cycles_r <= 16'd0;
    end else begin
      if (hazard_stall && (stall_cycles_r != 16'hFFFF)) begin
        stall_cycles_r <= stall_cycles_r + 16'd1;
      end else begin
        stall_cycles_r <= stall_cycles_r;
      end
      if (freeze_s && (freeze_cycles_r != 16'hFFFF)) begin
        freeze_cycles_r <= freeze_cycles_r + 16'd1;
      end else begin
        freeze_cycles_r <= freeze_cycles_r;
      end
    end
  end

  assign stall_cycles  = stall_cycles_r;
  assign freeze_cycles = freeze_cycles_r;
`endif

endmodule

// File: tb/tb_hazard_tag_pipeline.sv
// Self-checking bench for hazard_tag_pipeline: directed scenarios plus a queue
// scoreboard following tags from ID to WB.
module tb_hazard_tag_pipeline;

  logic       clk;
  logic       rst_n;
  logic       forwarding_enable;
  logic       id_valid;
  logic [3:0] id_src1;
  logic [3:0] id_src2;
  logic       id_two_src;
  logic [3:0] id_dest;
  logic       id_wb_en;
  logic       id_mem_read;
  logic       flush;
  logic       mem_req;
  logic       mem_ready;
  logic       hazard_stall;
  logic       freeze;
  logic [3:0] exe_dest, mem_dest, wb_dest;
  logic       exe_wb_en, mem_wb_en, wb_wb_en;
  logic       exe_mem_read;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cycles;
  logic [15:0] freeze_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [5:0] sb_q[$];

  hazard_tag_pipeline #(.REG_ADDR_W(4)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .forwarding_enable (forwarding_enable),
    .id_valid          (id_valid),
    .id_src1           (id_src1),
    .id_src2           (id_src2),
    .id_two_src        (id_two_src),
    .id_dest           (id_dest),
    .id_wb_en          (id_wb_en),
    .id_mem_read       (id_mem_read),
    .flush             (flush),
    .mem_req           (mem_req),
    .mem_ready         (mem_ready),
    .hazard_stall      (hazard_stall),
    .freeze            (freeze),
    .exe_dest          (exe_dest),
    .mem_dest          (mem_dest),
    .wb_dest           (wb_dest),
    .exe_wb_en         (exe_wb_en),
    .mem_wb_en         (mem_wb_en),
    .wb_wb_en          (wb_wb_en),
`ifdef HAZARD_STATS_EN
    .stall_cycles      (stall_cycles),
    .freeze_cycles     (freeze_cycles),
`endif
    .exe_mem_read      (exe_mem_read)
  );

  wire [17:0] all_tags = {exe_dest, exe_wb_en, exe_mem_read,
                          mem_dest, mem_wb_en, 1'b0,
                          wb_dest, wb_wb_en, 1'b0};
  wire [5:0]  wb_tag = {wb_dest, wb_wb_en, 1'b0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [3:0] d, input logic w, input logic mr,
                          input logic [3:0] s1, input logic [3:0] s2, input logic two);
    id_valid = v; id_dest = d; id_wb_en = w; id_mem_read = mr;
    id_src1 = s1; id_src2 = s2; id_two_src = two;
  endtask

  task automatic idle(input int n);
    drive_id(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    flush = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; forwarding_enable = 1'b1; flush = 1'b0;
    drive_id(1'b1, 4'd3, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0);
    mem_req = 1'b1; mem_ready = 1'b0;
    #3;
    n_checks++;
    if (freeze !== 1'b0) begin $display("FAIL reset_freeze: got %0b expected 0", freeze); n_fail++; end
    n_checks++;
    if (hazard_stall !== 1'b0) begin $display("FAIL reset_stall: got %0b expected 0", hazard_stall); n_fail++; end
    cyc(); cyc();
    n_checks++;
    if (all_tags !== 18'd0) begin $display("FAIL reset_tags: got %h expected 0", all_tags); n_fail++; end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_load_use();
    forwarding_enable = 1'b1;
    drive_id(1'b1, 4'd3, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0);
    cyc();
    drive_id(1'b1, 4'd4, 1'b1, 1'b0, 4'd3, 4'd0, 1'b0);
    #1;
    n_checks++;
    if (hazard_stall !== 1'b1) begin $display("FAIL load_use_stall: got %0b expected 1", hazard_stall); n_fail++; end
    cyc();
    n_checks++;
    if ({exe_dest, exe_wb_en, mem_dest, mem_wb_en} !== {4'd0, 1'b0, 4'd3, 1'b1}) begin
      $display("FAIL load_use_bubble: got %h expected %h", {exe_dest, exe_wb_en, mem_dest, mem_wb_en}, {4'd0, 1'b0, 4'd3, 1'b1}); n_fail++;
    end
    n_checks++;
    if (hazard_stall !== 1'b0) begin $display("FAIL load_use_release: got %0b expected 0", hazard_stall); n_fail++; end
    cyc();
    n_checks++;
    if (exe_dest !== 4'd4) begin $display("FAIL load_use_issue: got %0d expected 4", exe_dest); n_fail++; end
    idle(3);
  endtask

  task automatic test_no_forwarding();
    forwarding_enable = 1'b0;
    drive_id(1'b1, 4'd5, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    cyc();
    drive_id(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    cyc();
    drive_id(1'b1, 4'd6, 1'b0, 1'b0, 4'd1, 4'd5, 1'b1);
    #1;
    n_checks++;
    if (hazard_stall !== 1'b1) begin $display("FAIL nofwd_src2_stall: got %0b expected 1", hazard_stall); n_fail++; end
    id_two_src = 1'b0;
    #1;
    n_checks++;
    if (hazard_stall !== 1'b0) begin $display("FAIL nofwd_src2_unused: got %0b expected 0", hazard_stall); n_fail++; end
    id_two_src = 1'b1; forwarding_enable = 1'b1;
    #1;
    n_checks++;
    if (hazard_stall !== 1'b0) begin $display("FAIL fwd_mem_alu: got %0b expected 0", hazard_stall); n_fail++; end
    forwarding_enable = 1'b0; id_valid = 1'b0;
    cyc();
    id_valid = 1'b1;
    #1;
    n_checks++;
    if (hazard_stall !== 1'b0 || wb_dest !== 4'd5) begin
      $display("FAIL nofwd_wb_no_hazard: got stall=%0b wb=%0d expected stall=0 wb=5", hazard_stall, wb_dest); n_fail++;
    end
    forwarding_enable = 1'b1;
    idle(3);
  endtask

  task automatic test_forward_alu();
    forwarding_enable = 1'b1;
    drive_id(1'b1, 4'd7, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    cyc();
    drive_id(1'b1, 4'd8, 1'b1, 1'b0, 4'd7, 4'd0, 1'b0);
    #1;
    n_checks++;
    if (hazard_stall !== 1'b0) begin $display("FAIL fwd_alu_stall: got %0b expected 0", hazard_stall); n_fail++; end
    cyc();
    n_checks++;
    if ({mem_dest, mem_wb_en} !== {4'd7, 1'b1}) begin $display("FAIL fwd_alu_mem: got %h expected 71", {mem_dest, mem_wb_en}); n_fail++; end
    id_valid = 1'b0;
    cyc();
    n_checks++;
    if ({wb_dest, wb_wb_en} !== {4'd7, 1'b1}) begin $display("FAIL fwd_alu_wb: got %h expected 71", {wb_dest, wb_wb_en}); n_fail++; end
    idle(3);
  endtask

  task automatic test_freeze();
    logic [17:0] held;
    held = {4'd11, 1'b1, 1'b0, 4'd10, 1'b1, 1'b0, 4'd9, 1'b1, 1'b0};
    forwarding_enable = 1'b1;
    for (int r = 9; r <= 11; r++) begin
      drive_id(1'b1, 4'(r), 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
      cyc();
    end
    drive_id(1'b1, 4'd12, 1'b1, 1'b0, 4'd11, 4'd0, 1'b0);
    forwarding_enable = 1'b0; mem_req = 1'b1; mem_ready = 1'b0; flush = 1'b1;
    #1;
    n_checks++;
    if (hazard_stall !== 1'b0) begin $display("FAIL freeze_masks_stall: got %0b expected 0", hazard_stall); n_fail++; end
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (freeze !== 1'b1) begin $display("FAIL freeze_active_%0d: got %0b expected 1", c, freeze); n_fail++; end
      cyc();
      n_checks++;
      if (all_tags !== held) begin $display("FAIL freeze_hold_%0d: got %h expected %h", c, all_tags, held); n_fail++; end
    end
    flush = 1'b0; id_src1 = 4'd0; mem_ready = 1'b1;
    #1;
    n_checks++;
    if (freeze !== 1'b0) begin $display("FAIL freeze_release: got %0b expected 0", freeze); n_fail++; end
    cyc();
    n_checks++;
    if (all_tags !== {4'd12, 1'b1, 1'b0, 4'd11, 1'b1, 1'b0, 4'd10, 1'b1, 1'b0}) begin
      $display("FAIL freeze_advance: got %h expected %h", all_tags, {4'd12, 1'b1, 1'b0, 4'd11, 1'b1, 1'b0, 4'd10, 1'b1, 1'b0}); n_fail++;
    end
    mem_req = 1'b0; mem_ready = 1'b0;
    #1;
    n_checks++;
    if (freeze !== 1'b0) begin $display("FAIL freeze_back_run: got %0b expected 0", freeze); n_fail++; end
    forwarding_enable = 1'b1;
  endtask

  task automatic test_flush();
    drive_id(1'b1, 4'd2, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    flush = 1'b1;
    cyc();
    n_checks++;
    if ({exe_dest, exe_wb_en} !== {4'd0, 1'b0}) begin $display("FAIL flush_bubble: got %h expected 00", {exe_dest, exe_wb_en}); n_fail++; end
    flush = 1'b0;
    cyc();
    n_checks++;
    if ({exe_dest, exe_wb_en} !== {4'd2, 1'b1}) begin $display("FAIL flush_after: got %h expected 21", {exe_dest, exe_wb_en}); n_fail++; end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp;
    logic [3:0] d;
    logic       w, v, f;
    forwarding_enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d = 4'($urandom_range(0, 15));
      w = 1'($urandom_range(0, 1));
      v = (i != 5);
      f = ((i % 4) == 3);
      drive_id(v, d, w, 1'b0, 4'($urandom_range(0, 15)), 4'd0, 1'b0);
      flush = f;
      exp = (v && !f) ? {d, w, 1'b0} : 6'd0;
      sb_q.push_back(exp);
      cyc();
      if (i >= 2) begin
        exp = sb_q.pop_front();
        n_checks++;
        if (wb_tag !== exp) begin $display("FAIL b2b_wb_%0d: got %h expected %h", i, wb_tag, exp); n_fail++; end
      end
    end
    idle(0);
    for (int j = 0; j < 2; j++) begin
      cyc();
      exp = sb_q.pop_front();
      n_checks++;
      if (wb_tag !== exp) begin $display("FAIL b2b_drain_%0d: got %h expected %h", j, wb_tag, exp); n_fail++; end
    end
  endtask

  task automatic test_reset_mid_wait();
    id_valid = 1'b0;
    mem_req = 1'b1; mem_ready = 1'b0;
    cyc();
    mem_req = 1'b0;
    #1;
    n_checks++;
    if (freeze !== 1'b1 || all_tags === 18'd0) begin
      $display("FAIL wait_state: got freeze=%0b tags=%h expected freeze=1 nonzero tags", freeze, all_tags); n_fail++;
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (freeze !== 1'b0 || all_tags !== 18'd0) begin
      $display("FAIL async_reset: got freeze=%0b tags=%h expected 0 0", freeze, all_tags); n_fail++;
    end
`ifdef HAZARD_STATS_EN
    n_checks++;
    if (stall_cycles !== 16'd0 || freeze_cycles !== 16'd0) begin
      $display("FAIL stats_reset: got %0d %0d expected 0 0", stall_cycles, freeze_cycles); n_fail++;
    end
`endif
    cyc();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (freeze !== 1'b0) begin $display("FAIL reset_to_run: got %0b expected 0", freeze); n_fail++; end
`ifdef HAZARD_STATS_EN
    mem_req = 1'b1;
    cyc(); cyc();
    mem_ready = 1'b1;
    cyc();
    n_checks++;
    if (freeze_cycles !== 16'd2) begin $display("FAIL stats_freeze: got %0d expected 2", freeze_cycles); n_fail++; end
`endif
    idle(2);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_forwarding();
    test_forward_alu();
    test_back_to_back();
    test_freeze();
    test_flush();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_tag_pipeline.md
Name: hazard_tag_pipeline

Overview:
- Producer side of the operand-forwarding interface: it carries destination tags (dest, wb_en, mem_read) from ID through the EXE, MEM and WB stages.
- It drives mem_dest/mem_wb_en/wb_dest/wb_wb_en to the forwarding unit.
- It raises a stall when the hazard cannot be resolved by forwarding.
- It also owns the pipeline freeze FSM for a variable-latency data memory.
- It sits beside the ID/EXE/MEM/WB pipeline registers in the ARM core.

Parameters:
- REG_ADDR_W, 4, register file address width; equals REGISTER_FILE_ADDRESS_LEN.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- forwarding_enable  in  1  forwarding path active
- id_valid  in  1  ID holds a real instruction
- id_src1  in  REG_ADDR_W  ID source 1 (Rn)
- id_src2  in  REG_ADDR_W  ID source 2 (Rm/Rd for store)
- id_two_src  in  1  id_src2 is actually read
- id_dest  in  REG_ADDR_W  ID destination
- id_wb_en  in  1  ID instruction writes back
- id_mem_read  in  1  ID instruction is a load
- flush  in  1  taken branch: squash ID instruction
- mem_req  in  1  MEM stage instruction accesses memory
- mem_ready  in  1  memory access completes this cycle
- hazard_stall  out  1  hold PC and IF/ID; insert a bubble
- freeze  out  1  hold the entire pipeline
- exe_dest, mem_dest, wb_dest  out  REG_ADDR_W  stage tags
- exe_wb_en, mem_wb_en, wb_wb_en  out  1  stage write enables
- exe_mem_read  out  1  EXE stage is a load

Behaviour:
- Reset (async, rst_n=0):
  - All tag registers clear to 0 (dest=0, wb_en=0, mem_read=0).
  - FSM goes to RUN.
  - hazard_stall=0 and freeze=0 while in reset.
- Tag pipeline advance, on each rising edge when freeze=0:
  - wb <= mem
  - mem <= exe
  - exe <= bubble when (hazard_stall | flush | !id_valid); otherwise exe <= {id_dest, id_wb_en, id_mem_read}.
  - A bubble is all zeros.
- Freeze: when freeze=1, all three stage tags hold.
- Source-use match (per source): src1 always counts. src2 counts only when id_two_src=1.
- Hazard with forwarding_enable=1:
  - hazard_stall = id_valid & exe_wb_en & exe_mem_read & (a used src equals exe_dest).
  - This is the load-use case only; all other hazards are resolved by forwarding.
- Hazard with forwarding_enable=0:
  - hazard_stall = id_valid & ((exe_wb_en & used src == exe_dest) | (mem_wb_en & used src == mem_dest)).
  - WB is never a hazard, because the register file writes on the falling edge.
- hazard_stall is combinational from the stage registers and the ID inputs, so it responds in zero cycles.
- flush has priority over the hazard bubble in effect: both insert a bubble.
- Freeze FSM (two states):
  - RUN: if mem_req & !mem_ready, go to WAIT. freeze = mem_req & !mem_ready (combinational, so the first wait cycle is frozen).
  - WAIT: freeze = !mem_ready. When mem_ready=1, return to RUN and release the freeze in the same cycle.
- freeze masks hazard_stall: output hazard_stall = raw_hazard & !freeze.
- Tags hold stable during freeze, so forwarding selects stay consistent.
- No special case for r15 or r0; all addresses are compared.
- Simultaneous freeze and flush: the freeze wins and the flush is ignored. The fetch stage must hold flush until released; this is documented core-level behaviour.
- Reset asserted mid-WAIT: the FSM is forced to RUN and the tags are cleared.

Optional Feature:
- Macro: HAZARD_STATS_EN
- Defined:
  - Adds output stall_cycles[15:0], a saturating count of cycles with hazard_stall=1.
  - Adds output freeze_cycles[15:0], a saturating count of cycles with freeze=1.
  - Both reset to 0 and hold at 16'hFFFF.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- The shared Constants.v already holds REGISTER_FILE_ADDRESS_LEN. Add to it:
  - FREEZE_FSM_RUN=1'b0 and FREEZE_FSM_WAIT=1'b1.
  - A TAG_BUBBLE constant.
- Natural sub-module: dest_tag_stage, one register stage of {dest, wb_en, mem_read} with async clear, a hold input and a bubble input. It is instantiated three times.

Test Plan:
- Load r3 in EXE (exe_mem_read=1), ID src1=3, forwarding_enable=1 -> hazard_stall=1 for one cycle. Next cycle exe tag is the bubble (wb_en=0) and mem_dest=3, mem_wb_en=1.
- forwarding_enable=0, ALU write r5 in MEM, ID src2=5, id_two_src=1 -> hazard_stall=1. With id_two_src=0 -> hazard_stall=0.
- forwarding_enable=1, ALU write r7 in EXE, ID src1=7 -> no stall. After 1 cycle mem_dest=7; after 2 cycles wb_dest=7, wb_wb_en=1.
- mem_req=1 with mem_ready low for 3 cycles -> freeze=1 for exactly those 3 cycles, tags unchanged. Pipeline advances in the cycle mem_ready=1.
- flush=1 with a valid ID instruction writing r2 -> next exe tag is the bubble (exe_wb_en=0).
- rst_n=0 asynchronously during WAIT -> freeze=0 and all tags 0 immediately, without waiting for a clock edge. With HAZARD_STATS_EN, the counters read 0.
